// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end feeding the IF/ID register.
// Issues sequential fetch addresses, with up to DEPTH requests in flight.
// Returned instructions are buffered in order and presented one per cycle.
// A redirect flushes the queue and discards every stale in-flight response.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   imem_req/imem_addr       fetch request (memory accepts every request)
//   imem_rvalid/imem_rdata   in-order responses, latency >= 1
//   stall                    decode stall, hold head entry
//   redirect/redirect_pc     flush and restart fetch at redirect_pc
//   out_valid/out_pc/out_instr  head entry ({0,0} when empty)
//   occupancy                entries currently queued
module fetch_queue #(
    parameter int          PC_W     = 9,
    parameter int          INS_W    = 32,
    parameter int          DEPTH    = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [PC_W-1:0]            imem_addr,
    input  logic                       imem_rvalid,
    input  logic [INS_W-1:0]           imem_rdata,
    input  logic                       stall,
    input  logic                       redirect,
    input  logic [PC_W-1:0]            redirect_pc,
    output logic                       out_valid,
    output logic [PC_W-1:0]            out_pc,
    output logic [INS_W-1:0]           out_instr,
    output logic [$clog2(DEPTH):0]     occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PC_W-1:0]  r_fetch_pc;
    // PC of the next response that will be kept. Every kept response belongs
    // to the sequential run started at the last redirect/reset, so a counter
    // replaces a FIFO of issued addresses.
    logic [PC_W-1:0]  r_tag_pc;
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [CW-1:0]    r_occ;
    logic [CW-1:0]    r_out;
    logic [CW-1:0]    r_drop;
    logic [PC_W-1:0]  r_q_pc  [DEPTH];
    logic [INS_W-1:0] r_q_ins [DEPTH];

    logic [CW:0]      w_credit;
    logic             w_issue;
    logic             w_rsp;
    logic             w_drop;
    logic             w_push;
    logic             w_pop;

    // Credits cover both queued entries and in-flight requests, so a
    // response always finds a free slot.
    assign w_credit  = {1'b0, r_occ} + {1'b0, r_out};
    assign w_issue   = !reset && !redirect && (w_credit < (CW+1)'(DEPTH));
    assign w_rsp     = imem_rvalid && (r_out != '0);
    assign w_drop    = w_rsp && (r_drop != '0);
    assign w_push    = w_rsp && !w_drop && !redirect;
    assign w_pop     = (r_occ != '0) && !stall && !redirect;

    assign imem_req  = w_issue;
    assign imem_addr = r_fetch_pc;
    assign occupancy = r_occ;
    assign out_valid = (r_occ != '0);
    assign out_pc    = out_valid ? r_q_pc[r_head]  : '0;
    assign out_instr = out_valid ? r_q_ins[r_head] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= PC_W'(RESET_PC);
            r_tag_pc   <= PC_W'(RESET_PC);
            r_head     <= '0;
            r_tail     <= '0;
            r_occ      <= '0;
            r_out      <= '0;
            r_drop     <= '0;
        end else begin
            r_out <= r_out - CW'(w_rsp) + CW'(w_issue);
            if (redirect) begin
                r_fetch_pc <= redirect_pc;
                r_tag_pc   <= redirect_pc;
                r_head     <= '0;
                r_tail     <= '0;
                r_occ      <= '0;
                // Everything still in flight after this cycle is stale; the
                // response arriving now is already gated out of the push.
                r_drop     <= r_out - CW'(w_rsp);
            end else begin
                if (w_issue) r_fetch_pc <= r_fetch_pc + PC_W'(4);
                if (w_drop)  r_drop     <= r_drop - CW'(1);
                if (w_push) begin
                    r_tail   <= r_tail + AW'(1);
                    r_tag_pc <= r_tag_pc + PC_W'(4);
                end
                if (w_pop) r_head <= r_head + AW'(1);
                r_occ <= r_occ + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_tail]  <= r_tag_pc;
            r_q_ins[r_tail] <= imem_rdata;
        end
    end
endmodule
